// File: rtl/regfile_pkg.sv
// Shared register-file constants and the read-port dump FSM state encoding.
package regfile_pkg;
  localparam int ADDR_WIDTH = 5;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    PRESENT
  } dump_state_t;
endpackage

// File: rtl/regfile_dump_reader.sv
// Walks a register address range on a spare read port and streams each word out
// as a valid/ready (index, data) beat; read-only with respect to the register file.
//   state   | meaning
//   IDLE    | no dump in progress, waiting for start
//   WAIT    | read_address driven, counting down the read latency
//   PRESENT | captured word offered on dump_*, waiting for dump_ready
module regfile_dump_reader #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] first_addr,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  output logic [ADDR_WIDTH-1:0] read_address,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [ADDR_WIDTH-1:0] dump_index,
  output logic [DATA_WIDTH-1:0] dump_data,
  output logic                  dump_last,
  output logic                  busy,
  output logic                  done
);
  import regfile_pkg::*;

  localparam logic [2:0] LAT_LOAD = 3'(RD_LATENCY);

  dump_state_t           state, state_n;
  logic [ADDR_WIDTH-1:0] remaining, remaining_n;
  logic [2:0]            lat_cnt, lat_cnt_n;
  logic [ADDR_WIDTH-1:0] read_address_n, dump_index_n;
  logic [DATA_WIDTH-1:0] dump_data_n;
  logic                  dump_valid_n, dump_last_n, busy_n, done_n;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      remaining    <= '0;
      lat_cnt      <= '0;
      read_address <= '0;
      dump_valid   <= 1'b0;
      dump_index   <= '0;
      dump_data    <= '0;
      dump_last    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_n;
      remaining    <= remaining_n;
      lat_cnt      <= lat_cnt_n;
      read_address <= read_address_n;
      dump_valid   <= dump_valid_n;
      dump_index   <= dump_index_n;
      dump_data    <= dump_data_n;
      dump_last    <= dump_last_n;
      busy         <= busy_n;
      done         <= done_n;
    end
  end

  // The range is held as the current address plus a count of words still to go,
  // so a wrapping range (last < first) needs no special handling.
  always_comb begin
    state_n        = state;
    remaining_n    = remaining;
    lat_cnt_n      = lat_cnt;
    read_address_n = read_address;
    dump_valid_n   = dump_valid;
    dump_index_n   = dump_index;
    dump_data_n    = dump_data;
    dump_last_n    = dump_last;
    busy_n         = busy;
    done_n         = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          read_address_n = first_addr;
          remaining_n    = last_addr - first_addr;
          lat_cnt_n      = LAT_LOAD;
          busy_n         = 1'b1;
          state_n        = WAIT;
        end
      end
      WAIT: begin
        lat_cnt_n = lat_cnt - 3'd1;
        if (lat_cnt == 3'd1) begin
          dump_data_n  = read_data;
          dump_index_n = read_address;
          dump_last_n  = (remaining == '0);
          dump_valid_n = 1'b1;
          state_n      = PRESENT;
        end
      end
      PRESENT: begin
        if (dump_ready) begin
          dump_valid_n = 1'b0;
          if (dump_last) begin
            busy_n      = 1'b0;
            done_n      = 1'b1;
            dump_last_n = 1'b0;
            state_n     = IDLE;
          end else begin
            read_address_n = read_address + 1'b1;
            remaining_n    = remaining - 1'b1;
            lat_cnt_n      = LAT_LOAD;
            state_n        = WAIT;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule
